// File: rtl/inv_aes.sv
// Iterative AES-128 inverse cipher: expands the key forward to round key 10,
// then walks the schedule backward while performing one decryption round per clock.
module inv_aes (
  input  logic         clk,
  input  logic         rs,
  input  logic [127:0] plain,
  input  logic [127:0] key,
  input  logic         start,
  output logic [127:0] cipher,
  output logic         ready
);

  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} state_t;

  state_t       r_state, w_nextState;
  logic [127:0] r_data, r_rk, r_cipher;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;

  logic [7:0]   w_rconPrev, w_rconUse;
  logic [31:0]  w_subIn, w_subWord, w_fw0, w_fw1, w_fw2, w_fw3;
  logic [127:0] w_rkFwd, w_rkInv, w_rkStep, w_roundPre, w_roundOut;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] invXtime(input logic [7:0] a);
    return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^k), k=1..7; maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gfMul(s, s);
      r = gfMul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gfInv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gfInv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subRot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = invSbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  // Coefficients 0e/0b/0d/09 built from the x2, x4, x8 xtime chain.
  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction

  // One shared SubWord(RotWord()) serves both schedule directions.
  assign w_rconPrev = invXtime(r_rcon);
  assign w_subIn    = (r_state == KEXP) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);
  assign w_rconUse  = (r_state == KEXP) ? r_rcon : w_rconPrev;
  assign w_subWord  = subRot(w_subIn) ^ {w_rconUse, 24'h000000};
  assign w_fw0      = r_rk[127:96] ^ w_subWord;
  assign w_fw1      = r_rk[95:64] ^ w_fw0;
  assign w_fw2      = r_rk[63:32] ^ w_fw1;
  assign w_fw3      = r_rk[31:0] ^ w_fw2;
  assign w_rkFwd    = {w_fw0, w_fw1, w_fw2, w_fw3};
  assign w_rkInv    = {r_rk[127:96] ^ w_subWord, r_rk[95:64] ^ r_rk[127:96],
                       r_rk[63:32] ^ r_rk[95:64], r_rk[31:0] ^ r_rk[63:32]};
  assign w_rkStep   = (r_state == KEXP) ? w_rkFwd : w_rkInv;

  assign w_roundPre = invShiftSub(r_data) ^ r_rk;
  assign w_roundOut = (r_cnt == 4'd0) ? w_roundPre : invMixColumns(w_roundPre);

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_nextState = KEXP;
      KEXP:       if (r_cnt == 4'd9) w_nextState = ADDK;
      ADDK:       w_nextState = ROUND;
      ROUND:      if (r_cnt == 4'd0) w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) r_state <= IDLE;
    else    r_state <= w_nextState;
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_data   <= '0;
      r_rk     <= '0;
      r_cipher <= '0;
      r_rcon   <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_data <= plain;
            r_rk   <= key;
            r_rcon <= 8'h01;
            r_cnt  <= 4'd0;
          end
        end
        KEXP: begin
          r_rk   <= w_rkStep;
          r_rcon <= xtime(r_rcon);
          r_cnt  <= r_cnt + 4'd1;
        end
        ADDK: begin
          r_data <= r_data ^ r_rk;
          r_rk   <= w_rkStep;
          r_rcon <= w_rconPrev;
          r_cnt  <= 4'd9;
        end
        ROUND: begin
          r_data <= w_roundOut;
          r_rk   <= w_rkStep;
          r_rcon <= w_rconPrev;
          if (r_cnt == 4'd0) r_cipher <= w_roundOut;
          else               r_cnt    <= r_cnt - 4'd1;
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  assign cipher = r_cipher;
  assign ready  = (r_state == DONE);

endmodule

// File: tb/tb_inv_aes.sv
// Scoreboard bench for inv_aes: directed FIPS-197 vectors plus round-trips
// through an independent forward AES-128 model.
module tb_inv_aes;

  logic         clk, rs, start, ready;
  logic [127:0] plain, key, cipher;

  inv_aes dut (
    .clk    (clk),
    .rs     (rs),
    .plain  (plain),
    .key    (key),
    .start  (start),
    .cipher (cipher),
    .ready  (ready)
  );

  typedef struct {
    logic [127:0] exp;
    int           acc;
    int           tag;
  } sbItem_t;

  sbItem_t sb[$];
  int      tests = 0;
  int      failures = 0;
  int      cycleCount = 0;
  int      tagCounter = 0;
  logic    prevReady = 1'b0;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [7:0] sboxRef(input logic [7:0] a);
    int idx;
    idx = int'(a);
    return SBOX_TABLE[2047-8*idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] keyStep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sboxRef(w3[23:16]) ^ rc, sboxRef(w3[15:8]), sboxRef(w3[7:0]), sboxRef(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Forward cipher: SubBytes + ShiftRows, MixColumns except in the last round.
  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, t, rk;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    rc = 8'h01;
    s  = pt ^ rk;
    for (int round = 1; round <= 10; round++) begin
      rk = keyStep(rk, rc);
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(4*c+r) -: 8] = sboxRef(s[127-8*(4*((c+r)%4)+r) -: 8]);
      s = t;
      if (round < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [127:0] exp);
    sbItem_t item;
    item.exp = exp;
    item.acc = cycleCount + 1;
    item.tag = tagCounter;
    tagCounter++;
    sb.push_back(item);
  endtask

  // Drives one request for a single clock; start falls right after acceptance.
  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp);
    @(negedge clk);
    plain = p;
    key   = k;
    start = 1'b1;
    pushExpected(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ready_after_accept", {127'd0, ready}, 128'd0);
  endtask

  task automatic waitReady(input int maxCycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      failures++;
      $display("[TB] FAIL ready_timeout: got ready=0 expected ready=1 within %0d cycles", maxCycles);
    end
  endtask

  // Monitor: every rising edge of ready consumes one scoreboard entry.
  always @(negedge clk) begin
    sbItem_t item;
    if (ready && !prevReady) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_ready: got cipher=%h expected no result", cipher);
      end else begin
        item = sb.pop_front();
        checkOutput($sformatf("result_%0d", item.tag), cipher, item.exp);
        checkOutput($sformatf("latency_%0d", item.tag), 128'(cycleCount - item.acc), 128'd21);
      end
    end
    prevReady = ready;
  end

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZERO_PT = 128'h140f0f1011b5223d79587717ffd9ec3a;
  localparam logic [127:0] B2B_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] k, pt;
    rs    = 1'b1;
    start = 1'b0;
    plain = '0;
    key   = '0;
    #2;
    checkOutput("reset_ready", {127'd0, ready}, 128'd0);
    checkOutput("reset_cipher", cipher, 128'd0);
    @(negedge clk);
    rs = 1'b0;

    applyStimulus(128'd0, 128'd0, ZERO_PT);
    waitReady(40);
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    waitReady(40);
    checkOutput("done_hold", cipher, C1_PT);

    // Back-to-back: start stays high, new block presented while ready is high.
    @(negedge clk);
    plain = 128'd0;
    key   = 128'd0;
    start = 1'b1;
    pushExpected(ZERO_PT);
    waitReady(40);
    plain = B2B_CT;
    key   = 128'd0;
    pushExpected(128'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_ready_drop", {127'd0, ready}, 128'd0);
    checkOutput("b2b_cipher_hold", cipher, ZERO_PT);
    start = 1'b0;
    waitReady(40);

    // Busy ignore: scramble inputs and start while the rounds run.
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = ~start;
      plain = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b0;
    waitReady(40);

    // Mid-run reset aborts without leaving a result behind.
    applyStimulus(128'd0, 128'd0, ZERO_PT);
    repeat (8) @(negedge clk);
    #2;
    rs = 1'b1;
    #1;
    checkOutput("abort_ready", {127'd0, ready}, 128'd0);
    checkOutput("abort_cipher", cipher, 128'd0);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    @(negedge clk);
    rs = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("post_abort_ready", {127'd0, ready}, 128'd0);
    checkOutput("post_abort_cipher", cipher, 128'd0);
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    waitReady(40);

    for (int i = 0; i < 100; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(aesEncrypt(pt, k), k, pt);
      waitReady(40);
    end

    @(negedge clk);
    checkOutput("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
